// File: rtl/game_phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_phase_sequencer_if
//   Bundles the control inputs and the display/symbol-generator outputs of the
//   game phase sequencer.
//
//   Signals:
//     start        single-cycle start/restart request
//     pause        level-sensitive freeze of the phase timers
//     user_count   user's answer, sampled at the end of ANSWER
//     game_count   true symbol count, sampled at the end of ANSWER
//     phase        0=IDLE 1=PRELIM 2=GAME 3=ANSWER 4=POST 5=LOST 6=WON
//     phase_start  one-cycle pulse on entry to a timed phase
//     tick         one-cycle pulse per countdown tick
//     countdown    remaining ticks in the current phase
//     level        current level, 0-based
//     level_chng   one-cycle pulse when the level increments
//     score        |user_count - game_count| latched at the end of ANSWER
//     loss / win   high while in LOST / WON
//
//   Modports:
//     master  the sequencer (consumes controls, drives status)
//     slave   the controlling/observing side
// -----------------------------------------------------------------------------
interface game_phase_sequencer_if #(
  parameter int COUNT_W = 7,
  parameter int CD_W    = 4,
  parameter int LEVEL_W = 5
);
  logic               start;
  logic               pause;
  logic [COUNT_W-1:0] user_count;
  logic [COUNT_W-1:0] game_count;
  logic [2:0]         phase;
  logic               phase_start;
  logic               tick;
  logic [CD_W-1:0]    countdown;
  logic [LEVEL_W-1:0] level;
  logic               level_chng;
  logic [COUNT_W-1:0] score;
  logic               loss;
  logic               win;

  modport master (
    input  start, pause, user_count, game_count,
    output phase, phase_start, tick, countdown, level, level_chng, score,
           loss, win
  );

  modport slave (
    output start, pause, user_count, game_count,
    input  phase, phase_start, tick, countdown, level, level_chng, score,
           loss, win
  );
endinterface

// File: rtl/game_phase_sequencer.sv
// -----------------------------------------------------------------------------
// game_phase_sequencer
//   Level/period controller for the counting game. An internal divider turns
//   Clk100M into countdown ticks; each level runs PRELIM -> GAME -> ANSWER ->
//   POST. At the end of ANSWER the user's count is scored against the true
//   count; a pass advances the level (or wins after the last one), a fail
//   ends the game in LOST. LOST/WON wait for a new start.
//
//   Ports:
//     Clk100M  system clock
//     reset    synchronous, active-high reset (priority over everything)
//     bus      game_phase_sequencer_if.master: start/pause/user_count/
//              game_count in; phase, phase_start, tick, countdown, level,
//              level_chng, score, loss, win out
//
//   Parameters:
//     TICK_DIV   Clk100M cycles per countdown tick (>=2)
//     PRELIM_S, GAME_S, ANSWER_S, POST_S   phase durations in ticks (>=1)
//     NUM_LEVELS number of levels (1..2^LEVEL_W)
//     LEVEL_W, COUNT_W, CD_W   output widths (CD_W holds the largest *_S)
//     TOL        largest score that still counts as a pass
// -----------------------------------------------------------------------------
module game_phase_sequencer #(
  parameter int TICK_DIV   = 100000000,
  parameter int PRELIM_S   = 3,
  parameter int GAME_S     = 10,
  parameter int ANSWER_S   = 5,
  parameter int POST_S     = 2,
  parameter int NUM_LEVELS = 16,
  parameter int LEVEL_W    = 5,
  parameter int COUNT_W    = 7,
  parameter int CD_W       = 4,
  parameter int TOL        = 0
) (
  input  logic                    Clk100M,
  input  logic                    reset,
  game_phase_sequencer_if.master  bus
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]    CD_PRELIM  = CD_W'(PRELIM_S);
  localparam logic [CD_W-1:0]    CD_GAME    = CD_W'(GAME_S);
  localparam logic [CD_W-1:0]    CD_ANSWER  = CD_W'(ANSWER_S);
  localparam logic [CD_W-1:0]    CD_POST    = CD_W'(POST_S);
  localparam logic [CD_W-1:0]    CD_ONE     = CD_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [COUNT_W-1:0] TOL_C      = COUNT_W'(TOL);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRELIM = 3'd1,
    GAME   = 3'd2,
    ANSWER = 3'd3,
    POST   = 3'd4,
    LOST   = 3'd5,
    WON    = 3'd6
  } phase_t;

  phase_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [CD_W-1:0]    cd, cd_nxt;
  logic [LEVEL_W-1:0] level_r, level_nxt;
  logic [COUNT_W-1:0] score_r, score_nxt;
  logic               phase_start_r, phase_start_nxt;
  logic               level_chng_r, level_chng_nxt;

  logic               timed;
  logic               tick_int;
  logic [COUNT_W-1:0] diff;

  // Magnitude of the difference without wrap: subtract the smaller operand
  // from the larger one.
  function automatic logic [COUNT_W-1:0] abs_diff(
    input logic [COUNT_W-1:0] a,
    input logic [COUNT_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Countdown loaded on entry to each timed phase.
  function automatic logic [CD_W-1:0] dur_of(input phase_t p);
    case (p)
      PRELIM:  return CD_PRELIM;
      GAME:    return CD_GAME;
      ANSWER:  return CD_ANSWER;
      POST:    return CD_POST;
      default: return '0;
    endcase
  endfunction

  assign timed    = (state == PRELIM) || (state == GAME) ||
                    (state == ANSWER) || (state == POST);
  // tick is combinational on pause so a frozen timer never emits a tick.
  assign tick_int = timed && !bus.pause && (div_cnt == DIV_LAST);
  assign diff     = abs_diff(bus.user_count, bus.game_count);

  always_comb begin
    state_nxt       = state;
    div_nxt         = div_cnt;
    cd_nxt          = cd;
    level_nxt       = level_r;
    score_nxt       = score_r;
    phase_start_nxt = 1'b0;
    level_chng_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt       = PRELIM;
          level_nxt       = '0;
          phase_start_nxt = 1'b1;
        end
      end

      LOST, WON: begin
        if (bus.start) begin
          state_nxt       = PRELIM;
          level_nxt       = '0;
          score_nxt       = '0;
          phase_start_nxt = 1'b1;
        end
      end

      PRELIM, GAME, ANSWER, POST: begin
        if (!bus.pause) begin
          if (!tick_int) begin
            div_nxt = div_cnt + 1'b1;
          end else if (cd > CD_ONE) begin
            div_nxt = '0;
            cd_nxt  = cd - 1'b1;
          end else begin
            // Last tick of the phase: pick the successor.
            div_nxt = '0;
            case (state)
              PRELIM: begin
                state_nxt       = GAME;
                phase_start_nxt = 1'b1;
              end
              GAME: begin
                state_nxt       = ANSWER;
                phase_start_nxt = 1'b1;
              end
              ANSWER: begin
                score_nxt = diff;
                if (diff <= TOL_C) begin
                  state_nxt       = POST;
                  phase_start_nxt = 1'b1;
                end else begin
                  state_nxt = LOST;
                  cd_nxt    = '0;
                end
              end
              POST: begin
                if (level_r == LEVEL_LAST) begin
                  state_nxt = WON;
                  cd_nxt    = '0;
                end else begin
                  state_nxt       = PRELIM;
                  level_nxt       = level_r + 1'b1;
                  level_chng_nxt  = 1'b1;
                  phase_start_nxt = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cd_nxt    = '0;
        div_nxt   = '0;
      end
    endcase

    // Every timed-phase entry restarts the divider and reloads the countdown,
    // so the new phase lasts exactly DUR*TICK_DIV unpaused cycles.
    if (phase_start_nxt) begin
      div_nxt = '0;
      cd_nxt  = dur_of(state_nxt);
    end
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      cd            <= '0;
      level_r       <= '0;
      score_r       <= '0;
      phase_start_r <= 1'b0;
      level_chng_r  <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_nxt;
      cd            <= cd_nxt;
      level_r       <= level_nxt;
      score_r       <= score_nxt;
      phase_start_r <= phase_start_nxt;
      level_chng_r  <= level_chng_nxt;
    end
  end

  assign bus.phase       = state;
  assign bus.phase_start = phase_start_r;
  assign bus.tick        = tick_int;
  assign bus.countdown   = cd;
  assign bus.level       = level_r;
  assign bus.level_chng  = level_chng_r;
  assign bus.score       = score_r;
  assign bus.loss        = (state == LOST);
  assign bus.win         = (state == WON);

endmodule

// File: tb/tb_game_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_phase_sequencer
//   Drives two sequencers (TOL=0 and TOL=2) with identical stimulus: directed
//   scenarios followed by randomized start/pause/count/reset traffic. Each
//   cycle the outputs are compared with a reference model that tracks, per
//   phase, only the number of unpaused cycles elapsed since entry and derives
//   countdown/tick from that with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_game_phase_sequencer;
  localparam int TICK_DIV   = 4;
  localparam int PRELIM_S   = 2;
  localparam int GAME_S     = 3;
  localparam int ANSWER_S   = 2;
  localparam int POST_S     = 1;
  localparam int NUM_LEVELS = 2;
  localparam int LEVEL_W    = 5;
  localparam int COUNT_W    = 7;
  localparam int CD_W       = 4;

  logic               Clk100M = 1'b0;
  logic               reset;
  logic               start;
  logic               pause;
  logic [COUNT_W-1:0] user_count;
  logic [COUNT_W-1:0] game_count;

  int checks = 0;
  int errors = 0;
  int ps_cnt, lc_cnt, game_cyc;

  // Reference model state, one slot per DUT.
  int m_phase [2];
  int m_el    [2];
  int m_level [2];
  int m_score [2];
  bit m_entry [2];
  bit m_lchg  [2];
  int tol_of  [2];

  always #5 Clk100M = ~Clk100M;

  game_phase_sequencer_if #(.COUNT_W(COUNT_W), .CD_W(CD_W), .LEVEL_W(LEVEL_W)) bus_a ();
  game_phase_sequencer_if #(.COUNT_W(COUNT_W), .CD_W(CD_W), .LEVEL_W(LEVEL_W)) bus_b ();

  assign bus_a.start      = start;
  assign bus_a.pause      = pause;
  assign bus_a.user_count = user_count;
  assign bus_a.game_count = game_count;
  assign bus_b.start      = start;
  assign bus_b.pause      = pause;
  assign bus_b.user_count = user_count;
  assign bus_b.game_count = game_count;

  game_phase_sequencer #(
    .TICK_DIV(TICK_DIV), .PRELIM_S(PRELIM_S), .GAME_S(GAME_S),
    .ANSWER_S(ANSWER_S), .POST_S(POST_S), .NUM_LEVELS(NUM_LEVELS),
    .LEVEL_W(LEVEL_W), .COUNT_W(COUNT_W), .CD_W(CD_W), .TOL(0)
  ) dut_a (
    .Clk100M(Clk100M),
    .reset  (reset),
    .bus    (bus_a.master)
  );

  game_phase_sequencer #(
    .TICK_DIV(TICK_DIV), .PRELIM_S(PRELIM_S), .GAME_S(GAME_S),
    .ANSWER_S(ANSWER_S), .POST_S(POST_S), .NUM_LEVELS(NUM_LEVELS),
    .LEVEL_W(LEVEL_W), .COUNT_W(COUNT_W), .CD_W(CD_W), .TOL(2)
  ) dut_b (
    .Clk100M(Clk100M),
    .reset  (reset),
    .bus    (bus_b.master)
  );

  task automatic chk(input int inst, input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] t=%0t observed=%0d expected=%0d", tag, inst, $time, obs, exp);
    end
  endtask

  function automatic int dur_of(input int p);
    case (p)
      1:       return PRELIM_S;
      2:       return GAME_S;
      3:       return ANSWER_S;
      4:       return POST_S;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_timed(input int p);
    return (p >= 1) && (p <= 4);
  endfunction

  task automatic init_model();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_el[i] = 0; m_level[i] = 0; m_score[i] = 0;
      m_entry[i] = 0; m_lchg[i] = 0;
    end
    tol_of[0] = 0;
    tol_of[1] = 2;
  endtask

  task automatic enter(input int i, input int p);
    m_phase[i] = p;
    m_el[i]    = 0;
    m_entry[i] = 1;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic step_model();
    int d;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = 0; m_el[i] = 0; m_level[i] = 0; m_score[i] = 0;
        m_entry[i] = 0; m_lchg[i] = 0;
      end else begin
        m_entry[i] = 0;
        m_lchg[i]  = 0;
        if (!is_timed(m_phase[i])) begin
          if (start) begin
            if (m_phase[i] != 0) m_score[i] = 0;
            m_level[i] = 0;
            enter(i, 1);
          end
        end else if (!pause) begin
          if (m_el[i] == dur_of(m_phase[i]) * TICK_DIV - 1) begin
            case (m_phase[i])
              1: enter(i, 2);
              2: enter(i, 3);
              3: begin
                d = (int'(user_count) > int'(game_count)) ?
                    int'(user_count) - int'(game_count) :
                    int'(game_count) - int'(user_count);
                m_score[i] = d;
                if (d <= tol_of[i]) enter(i, 4);
                else begin m_phase[i] = 5; m_el[i] = 0; end
              end
              default: begin
                if (m_level[i] == NUM_LEVELS - 1) begin
                  m_phase[i] = 6; m_el[i] = 0;
                end else begin
                  m_level[i] = m_level[i] + 1;
                  m_lchg[i]  = 1;
                  enter(i, 1);
                end
              end
            endcase
          end else begin
            m_el[i] = m_el[i] + 1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] o_phase, o_cd, o_level, o_score;
      logic [31:0] o_ps, o_tick, o_lc, o_loss, o_win;
      int e_cd;
      bit e_tick;
      if (i == 0) begin
        o_phase = 32'(bus_a.phase);  o_cd = 32'(bus_a.countdown);
        o_level = 32'(bus_a.level);  o_score = 32'(bus_a.score);
        o_ps = 32'(bus_a.phase_start); o_tick = 32'(bus_a.tick);
        o_lc = 32'(bus_a.level_chng);  o_loss = 32'(bus_a.loss);
        o_win = 32'(bus_a.win);
      end else begin
        o_phase = 32'(bus_b.phase);  o_cd = 32'(bus_b.countdown);
        o_level = 32'(bus_b.level);  o_score = 32'(bus_b.score);
        o_ps = 32'(bus_b.phase_start); o_tick = 32'(bus_b.tick);
        o_lc = 32'(bus_b.level_chng);  o_loss = 32'(bus_b.loss);
        o_win = 32'(bus_b.win);
      end
      e_cd   = is_timed(m_phase[i]) ? dur_of(m_phase[i]) - m_el[i] / TICK_DIV : 0;
      e_tick = is_timed(m_phase[i]) && !pause && (m_el[i] % TICK_DIV == TICK_DIV - 1);
      chk(i, "phase",       o_phase, 32'(m_phase[i]));
      chk(i, "countdown",   o_cd,    32'(e_cd));
      chk(i, "tick",        o_tick,  32'(e_tick));
      chk(i, "phase_start", o_ps,    32'(m_entry[i]));
      chk(i, "level",       o_level, 32'(m_level[i]));
      chk(i, "level_chng",  o_lc,    32'(m_lchg[i]));
      chk(i, "score",       o_score, 32'(m_score[i]));
      chk(i, "loss",        o_loss,  32'(m_phase[i] == 5));
      chk(i, "win",         o_win,   32'(m_phase[i] == 6));
    end
  endtask

  task automatic cycle();
    @(negedge Clk100M);
    check_outputs();
    if (bus_a.phase_start) ps_cnt++;
    if (bus_a.level_chng)  lc_cnt++;
    if (bus_a.phase == 3'd2) game_cyc++;
    step_model();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    user_count = '0; game_count = '0;
    @(posedge Clk100M);
    #1;
    init_model();
    cycle();
    chk(0, "reset_phase", 32'(bus_a.phase), 32'd0);
    chk(0, "reset_cd",    32'(bus_a.countdown), 32'd0);
    reset = 1'b0;

    // Normal level pass
    user_count = 7'd5; game_count = 7'd5;
    start = 1'b1; cycle(); start = 1'b0;
    ps_cnt = 0; lc_cnt = 0;
    run(32);
    chk(0, "pass_phase_start_count", 32'(ps_cnt), 32'd4);
    chk(0, "pass_level_chng", 32'(bus_a.level_chng), 32'd1);
    chk(0, "pass_level",      32'(bus_a.level), 32'd1);
    chk(0, "pass_phase",      32'(bus_a.phase), 32'd1);
    chk(0, "pass_score",      32'(bus_a.score), 32'd0);

    // Win
    run(32);
    chk(0, "win_phase", 32'(bus_a.phase), 32'd6);
    chk(0, "win_flag",  32'(bus_a.win), 32'd1);
    chk(0, "win_level", 32'(bus_a.level), 32'd1);
    chk(0, "win_level_chng_count", 32'(lc_cnt), 32'd1);
    run(3);

    // Loss
    start = 1'b1; cycle(); start = 1'b0;
    user_count = 7'd3; game_count = 7'd7;
    run(28);
    chk(0, "loss_phase", 32'(bus_a.phase), 32'd5);
    chk(0, "loss_flag",  32'(bus_a.loss), 32'd1);
    chk(0, "loss_score", 32'(bus_a.score), 32'd4);
    chk(0, "loss_level", 32'(bus_a.level), 32'd0);
    run(4);
    start = 1'b1; cycle(); start = 1'b0;
    chk(0, "restart_phase", 32'(bus_a.phase), 32'd1);
    chk(0, "restart_loss",  32'(bus_a.loss), 32'd0);
    chk(0, "restart_score", 32'(bus_a.score), 32'd0);

    // Pause mid-GAME
    user_count = 7'd5; game_count = 7'd5;
    run(8);
    game_cyc = 0;
    run(5);
    pause = 1'b1; run(10); pause = 1'b0;
    run(7);
    chk(0, "pause_game_cycles", 32'(game_cyc), 32'd22);
    chk(0, "pause_then_answer", 32'(bus_a.phase), 32'd3);
    run(12);

    // Start ignored during GAME, reset during ANSWER at level 1
    run(8);
    run(3);
    start = 1'b1; cycle(); start = 1'b0;
    run(8);
    chk(0, "start_ignored_answer", 32'(bus_a.phase), 32'd3);
    run(3);
    reset = 1'b1; cycle(); reset = 1'b0;
    chk(0, "midreset_phase", 32'(bus_a.phase), 32'd0);
    chk(0, "midreset_level", 32'(bus_a.level), 32'd0);
    chk(0, "midreset_cd",    32'(bus_a.countdown), 32'd0);
    chk(0, "midreset_ps",    32'(bus_a.phase_start), 32'd0);

    // Pause in IDLE does not block start
    pause = 1'b1; run(3);
    start = 1'b1; cycle(); start = 1'b0; pause = 1'b0;
    chk(0, "idle_pause_start_phase", 32'(bus_a.phase), 32'd1);
    chk(0, "idle_pause_start_cd",    32'(bus_a.countdown), 32'd2);

    // Absolute difference and tolerance
    user_count = 7'd0; game_count = 7'd127;
    run(28);
    chk(0, "absdiff_score", 32'(bus_a.score), 32'd127);
    chk(0, "absdiff_phase", 32'(bus_a.phase), 32'd5);
    chk(1, "absdiff_score", 32'(bus_b.score), 32'd127);
    start = 1'b1; cycle(); start = 1'b0;
    user_count = 7'd9; game_count = 7'd7;
    run(28);
    chk(0, "tol0_phase", 32'(bus_a.phase), 32'd5);
    chk(1, "tol2_phase", 32'(bus_b.phase), 32'd4);
    chk(1, "tol2_score", 32'(bus_b.score), 32'd2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      start = ($urandom_range(0, 11) == 0);
      pause = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 499) == 0);
      game_count = COUNT_W'($urandom_range(0, 127));
      r = $urandom_range(0, 7);
      if (r < 5)       user_count = game_count;
      else if (r == 5) user_count = (game_count < 7'd127) ? game_count + 7'd1 : game_count - 7'd1;
      else if (r == 6) user_count = (game_count >= 7'd2) ? game_count - 7'd2 : game_count + 7'd2;
      else             user_count = COUNT_W'($urandom_range(0, 127));
      cycle();
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_phase_sequencer.md
Name: game_phase_sequencer

Overview:
- Parametrised successor to the fixed level/period controller.
- Generates the 1 Hz-class tick internally from Clk100M and sequences PRELIM -> GAME -> ANSWER -> POST per level.
- Scores the user's answer against the generated count, then advances the level, declares a loss, or declares a win.
- Feeds the display (phase, countdown, level, score) and the symbol generator (phase, level_chng), and provides single-cycle entry strobes so downstream blocks need no separate blip stage.

Parameters:
- TICK_DIV, 100000000, Clk100M cycles per countdown tick (>=2)
- PRELIM_S, 3, PRELIM duration in ticks (>=1)
- GAME_S, 10, GAME duration in ticks (>=1)
- ANSWER_S, 5, ANSWER duration in ticks (>=1)
- POST_S, 2, POST duration in ticks (>=1)
- NUM_LEVELS, 16, number of levels (1..2^LEVEL_W)
- LEVEL_W, 5, level output width
- COUNT_W, 7, user/game count and score width
- CD_W, 4, countdown width; must hold the maximum *_S value
- TOL, 0, maximum score (absolute difference) that still counts as a pass

Ports:
- Clk100M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle start/restart request
- pause  in  1  level-sensitive freeze of the timers
- user_count  in  COUNT_W  user's answer, sampled at end of ANSWER
- game_count  in  COUNT_W  true symbol count, sampled at end of ANSWER
- phase  out  3  0=IDLE 1=PRELIM 2=GAME 3=ANSWER 4=POST 5=LOST 6=WON
- phase_start  out  1  one-cycle pulse on entry to PRELIM/GAME/ANSWER/POST
- tick  out  1  one-cycle pulse per countdown tick (timed phases only)
- countdown  out  CD_W  remaining ticks in the current phase
- level  out  LEVEL_W  current level, 0-based
- level_chng  out  1  one-cycle pulse when level increments
- score  out  COUNT_W  |user_count - game_count| latched at end of ANSWER
- loss  out  1  high while in LOST
- win  out  1  high while in WON

Behaviour:
- All state is registered on the rising edge of Clk100M. Reset has priority over every other input.
- Reset values: phase=IDLE, phase_start=0, tick=0, countdown=0, level=0, level_chng=0, score=0, loss=0, win=0, divider=0.
- Divider:
  - Counts 0..TICK_DIV-1 only in timed phases (PRELIM/GAME/ANSWER/POST) and only while pause=0.
  - tick is asserted in the cycle the divider holds TICK_DIV-1; the divider then wraps to 0.
  - The divider is cleared on every phase entry, so each phase lasts exactly DUR*TICK_DIV unpaused cycles.
- Phase entry (all timed phases):
  - Registered outputs show the new phase, countdown=DUR and phase_start=1, all in the same cycle.
  - phase_start lasts exactly one cycle.
- Countdown:
  - Decrements on each tick while greater than 1.
  - A tick with countdown==1 exits the phase; the next phase is entered on the following cycle.
- Pause:
  - Holds the divider and countdown; no tick is asserted while pause=1.
  - No effect in IDLE, LOST or WON.
  - A start request is still honoured while pause=1.
- Transitions:
  - IDLE --start--> PRELIM, with level=0.
  - PRELIM -> GAME -> ANSWER.
  - ANSWER exit:
    - Compute diff = |user_count - game_count| in COUNT_W-bit unsigned arithmetic, with no wrap (compare first, subtract the smaller from the larger).
    - Latch diff into score.
    - If diff <= TOL -> POST; else -> LOST.
  - POST exit:
    - If level == NUM_LEVELS-1 -> WON, level unchanged.
    - Else level increments, level_chng pulses in the same cycle PRELIM is entered, and the sequencer enters PRELIM.
  - LOST/WON --start--> PRELIM: level=0, score cleared, loss/win cleared.
- start is ignored in the timed phases.
- score holds its value until the next ANSWER exit or restart.
- loss and win are never high together, and neither is high outside LOST/WON.
- NUM_LEVELS=1: the first pass goes POST -> WON and level_chng never fires.
- Reset mid-phase: the next cycle shows the reset values; any partially elapsed phase is discarded.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, PRELIM_S=2, GAME_S=3, ANSWER_S=2, POST_S=1, NUM_LEVELS=2, TOL=0.
1. Normal level pass:
   - Stimulus: reset, then start pulse.
   - Response: PRELIM for 8 cycles with countdown 2,1; GAME for 12 cycles with countdown 3,2,1; ANSWER for 8 cycles.
   - With user=5, game=5 -> score=0, POST for 4 cycles, then level_chng pulse with level=1 and phase=PRELIM in the same cycle.
   - phase_start is seen exactly 4 times.
2. Loss:
   - Stimulus: at level 0, end of ANSWER with user=3, game=7.
   - Response: score=4, phase=LOST, loss=1 held, level=0.
   - A further start -> PRELIM with loss=0, score=0.
3. Win:
   - Stimulus: pass levels 0 and 1.
   - Response: after level-1 POST, phase=WON, win=1, level=1.
   - Exactly one level_chng over the whole run.
4. Pause:
   - Stimulus: assert pause for 10 cycles mid-GAME.
   - Response: countdown and divider frozen, no tick; GAME lasts 22 cycles in total.
   - Pause asserted in IDLE has no effect on a subsequent start.
5. Reset mid-operation and start ignored:
   - Stimulus: reset asserted during ANSWER at level 1.
   - Response: next cycle phase=IDLE, level=0, countdown=0, all pulses 0.
   - A start pulse during GAME leaves the sequence unchanged.
6. Absolute difference and tolerance:
   - Stimulus: user=0, game=127 with TOL=0 -> score=127, LOST.
   - Re-parametrise TOL=2: user=9, game=7 -> score=2, POST.
